// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared occupancy encoding and data word type
package fifo_stream_reader_pkg;
  localparam int DWIDTH = 16;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;
  typedef logic [DWIDTH-1:0] word_t;
endpackage

// File: rtl/fifo_stream_reader_skid_buffer_2.sv
// skid_buffer_2: 2-entry valid/ready register stage with registered push permit
module skid_buffer_2
  import fifo_stream_reader_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   occ_o,
  output logic         permit_o
);
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] out_q, out_d, skd_q, skd_d;
  logic         valid_q, permit_q, pop, psh;
  // next state: OUT is the older entry, SKD only fills when OUT is held
  always_comb begin
    pop   = valid_q & ready_i;
    psh   = push_i & permit_q;
    occ_d = clr_i ? OCC_EMPTY : occ_q + {1'b0, psh} - {1'b0, pop};
    out_d = (psh & (occ_q == OCC_EMPTY | (occ_q == OCC_ONE & pop))) ? data_i :
            (pop & occ_q == OCC_TWO) ? skd_q : out_q;
    skd_d = (psh & occ_q == OCC_ONE & ~pop) ? data_i : skd_q;
  end
  // storage plus valid/permit flags registered from the next occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= OCC_EMPTY;
      out_q    <= '0;
      skd_q    <= '0;
      valid_q  <= 1'b0;
      permit_q <= 1'b1;
    end else begin
      occ_q    <= occ_d;
      out_q    <= out_d;
      skd_q    <= skd_d;
      valid_q  <= occ_d != OCC_EMPTY;
      permit_q <= occ_d != OCC_TWO;
    end
  end
  assign data_o   = out_q;
  assign valid_o  = valid_q;
  assign occ_o    = occ_q;
  assign permit_o = permit_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: show-ahead FIFO to registered valid/ready stream with flush and item counter
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DWIDTH    = fifo_stream_reader_pkg::DWIDTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] fwd_count
);
  logic                 permit;
  logic [CNT_WIDTH-1:0] fwd_q;
  // flush pops unconditionally to drain; otherwise only the registered permit gates the pop
  assign fifo_rd_en = rst & ~fifo_empty & (flush | permit);
  skid_buffer_2 #(.W(DWIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (flush),
    .push_i   (fifo_rd_en & ~flush),
    .data_i   (fifo_dout),
    .ready_i  (m_ready),
    .data_o   (m_data),
    .valid_o  (m_valid),
    .occ_o    (occupancy),
    .permit_o (permit)
  );
  // count every completed handshake, including those during flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fwd_q <= '0;
    else if (m_valid & m_ready) fwd_q <= fwd_q + CNT_WIDTH'(1);
  end
  assign fwd_count = fwd_q;
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side companion to the team's show-ahead FIFO.
- On the FIFO side it sees `dout`, which is valid whenever the FIFO is not empty, and it drives `rd_en` to pop.
- On the downstream side it presents a registered valid/ready stream through a 2-entry skid buffer.
- Decouples the FIFO pop from downstream backpressure: `fifo_rd_en` never depends combinationally on `m_ready`. Adds flush/drain and a forwarded-item counter.

Parameters:
- DWIDTH, 16, width of the FIFO data word and of the stream payload.
- CNT_WIDTH, 32, width of the forwarded-item counter.

Ports:
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- fifo_dout  in  DWIDTH  FIFO head word, valid when fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop request; the word is sampled from fifo_dout in the same cycle.
- flush  in  1  synchronous flush/drain request.
- m_data  out  DWIDTH  stream payload, registered.
- m_valid  out  1  stream valid, registered.
- m_ready  in  1  downstream ready.
- occupancy  out  2  number of entries held, 0..2.
- fwd_count  out  CNT_WIDTH  number of completed handshakes, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asynchronous): occupancy=0, m_valid=0, m_data=0, skid register=0, fwd_count=0. fifo_rd_en=0 while in reset.
- Storage: output register OUT (drives m_data) and skid register SKD. occupancy=0 → both empty; 1 → OUT only; 2 → OUT and SKD, with SKD the younger entry.
- m_valid = (occupancy != 0), from a registered flag only.
- pop = m_valid & m_ready.
- Normal mode (flush=0): fifo_rd_en = ~fifo_empty & (occupancy != 2). push = fifo_rd_en.
- Next-state table by occupancy, push, pop:
  - occ 0, push: OUT<=fifo_dout, occ->1.
  - occ 1, push & pop: OUT<=fifo_dout, occ stays 1 (full throughput, one word per cycle).
  - occ 1, push only: SKD<=fifo_dout, occ->2.
  - occ 1, pop only: occ->0.
  - occ 2, pop: OUT<=SKD, occ->1 (push impossible at occ 2).
  - No push and no pop: hold.
- Latency: a word present at the FIFO head with occ=0 appears on m_data/m_valid one cycle after the fifo_rd_en cycle.
- Ordering: strict FIFO order; no word is duplicated or lost.
- Sustained throughput: 1 word/cycle when m_ready=1 and the FIFO is non-empty.
- Stalled downstream: after at most 2 pops, fifo_rd_en stays 0. m_data stays stable while m_valid=1 and m_ready=0.
- fifo_rd_en is never asserted while fifo_empty=1.
- Flush (flush=1):
  - A handshake in that cycle completes normally and is counted.
  - All held entries are discarded: occ->0 next cycle.
  - fifo_rd_en = ~fifo_empty; popped words are discarded, not stored.
  - Holding flush drains the FIFO completely.
  - The first cycle with flush=0 resumes normal mode from occ=0.
- fwd_count increments by 1 on every pop cycle and wraps from all-ones to 0.
- Reset mid-operation: all held entries are lost immediately. FIFO contents are the FIFO's own concern.
- No combinational path from m_ready or flush into m_valid/m_data. The only combinational path from flush is into fifo_rd_en.

Decomposition:
- Shared package (e.g. cicero_stream_pkg): occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2, and the typedef for a DWIDTH data word.
- One natural sub-module: skid_buffer_2, the generic 2-entry valid/ready register stage with registered push-permit output, instantiated once.
- Flush logic and fwd_count remain in the top module.

Test Plan:
- FIFO preloaded with 0x0001..0x0008, m_ready=1 constant → m_data 0x0001..0x0008 on 8 consecutive cycles; first m_valid one cycle after the first fifo_rd_en; fwd_count=8.
- Same preload, m_ready=0 for 10 cycles then 1 → exactly 2 pops, occupancy=2, m_data=0x0001 stable; then 8 in-order outputs with no gap after ready rises.
- m_ready toggling 1,0,1,0 with 5 words (0xA0..0xA4) → order preserved, no duplicates, fwd_count=5, fifo_rd_en never high with fifo_empty=1.
- occupancy=2 holding 0x11,0x12, FIFO holding 3 more words, flush held 4 cycles with m_ready=0 → occupancy=0, FIFO empty, m_valid=0, fwd_count unchanged; a following write 0x55 emerges first.
- rst=0 asserted asynchronously mid-stream with occupancy=2 → m_valid=0, occupancy=0, fwd_count=0 immediately, without waiting for a clock edge.
- CNT_WIDTH=4, 17 handshakes → fwd_count reads 1 (wrap after 15).
